// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive framer.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/uart_act_stretch.sv
// Activity-LED stretcher: holds the active-low LED on for HoldClks cycles after
// each start pulse, restarting the hold on every new pulse.
module uart_act_stretch #(
    parameter int unsigned HoldClks = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic led_o
);

    localparam int unsigned CntW = $clog2(HoldClks + 1);
    localparam logic [CntW-1:0] Reload = CntW'(HoldClks);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = Reload;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign led_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: synchronises RXD, frames start/data/parity/stop bits and reports
// the payload plus parity and framing errors as single-cycle pulses.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 217,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY        = PARITY_NONE,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned LED_HOLD_CLKS = 12_500_000
) (
    input  logic                 FPGA_CLK,
    input  logic                 RST_N,
    input  logic                 UART_RXD,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 BUSY,
    output logic                 ACT_LED
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

    rx_state_e state_q, state_d;

    logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 start_ok;

    logic fall, half_tick, bit_tick, par_calc;

    assign fall      = rxd_prev_q & ~rxd_sync_q;
    assign half_tick = (cnt_q == HalfEnd);
    assign bit_tick  = (cnt_q == BitEnd);
    // XOR of payload and received parity bit: 1 is the only legal result for odd parity.
    assign par_calc  = (^shift_q) ^ rxd_sync_q;

    always_ff @(posedge FPGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            rxd_meta_q   <= 1'b1;
            rxd_sync_q   <= 1'b1;
            rxd_prev_q   <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rxd_meta_q   <= UART_RXD;
            rxd_sync_q   <= rxd_meta_q;
            rxd_prev_q   <= rxd_sync_q;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) begin
                    state_d   = StStart;
                    bit_d     = '0;
                    par_err_d = 1'b0;
                end
            end
            StStart: begin
                if (half_tick) begin
                    cnt_d   = '0;
                    state_d = rxd_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LastData) begin
                        bit_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    state_d   = StStop;
                    par_err_d = (PARITY == PARITY_ODD) ? ~par_calc : par_calc;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    bit_d = bit_q + 1'b1;
                    if (!rxd_sync_q) begin
                        state_d = StBreak;
                    end else if (bit_q == LastStop) begin
                        state_d = StIdle;
                    end
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rxd_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        start_ok     = (state_q == StStart) && half_tick && !rxd_sync_q;
        if ((state_q == StStop) && bit_tick) begin
            if (!rxd_sync_q) begin
                frame_err_d = 1'b1;
            end else if (bit_q == LastStop) begin
                rx_valid_d   = 1'b1;
                parity_err_d = par_err_q;
                rx_data_d    = shift_q;
            end
        end
    end

    uart_act_stretch #(
        .HoldClks (LED_HOLD_CLKS)
    ) u_act_stretch (
        .clk_i   (FPGA_CLK),
        .rst_ni  (RST_N),
        .start_i (start_ok),
        .led_o   (ACT_LED)
    );

    assign RX_DATA    = rx_data_q;
    assign RX_VALID   = rx_valid_q;
    assign PARITY_ERR = parity_err_q;
    assign FRAME_ERR  = frame_err_q;
    assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: an 8N1 instance and an 8E1 instance, with a
// per-instance queue of expected {parity_err, data} popped on each RX_VALID.
module tb_uart_rx_framer;

    localparam int unsigned Cpb  = 16;
    localparam int unsigned Hold = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd, rxd_p;
    logic [7:0] data0, data1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1;
    logic       busy0, busy1, led0, led1;

    always #5 clk = ~clk;

    uart_rx_framer #(
        .CLKS_PER_BIT  (Cpb),
        .DATA_BITS     (8),
        .PARITY        (0),
        .STOP_BITS     (1),
        .LED_HOLD_CLKS (Hold)
    ) dut (
        .FPGA_CLK   (clk),
        .RST_N      (rst_n),
        .UART_RXD   (rxd),
        .RX_DATA    (data0),
        .RX_VALID   (valid0),
        .PARITY_ERR (perr0),
        .FRAME_ERR  (ferr0),
        .BUSY       (busy0),
        .ACT_LED    (led0)
    );

    uart_rx_framer #(
        .CLKS_PER_BIT  (Cpb),
        .DATA_BITS     (8),
        .PARITY        (2),
        .STOP_BITS     (1),
        .LED_HOLD_CLKS (Hold)
    ) dut_p (
        .FPGA_CLK   (clk),
        .RST_N      (rst_n),
        .UART_RXD   (rxd_p),
        .RX_DATA    (data1),
        .RX_VALID   (valid1),
        .PARITY_ERR (perr1),
        .FRAME_ERR  (ferr1),
        .BUSY       (busy1),
        .ACT_LED    (led1)
    );

    int total = 0;
    int bad   = 0;
    int vcnt0 = 0, vcnt1 = 0, fcnt0 = 0, fcnt1 = 0;
    logic [8:0] exp0[$];
    logic [8:0] exp1[$];
    logic [8:0] e0, e1;
    logic vprev0 = 1'b0, vprev1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side for the 8N1 instance.
    always @(negedge clk) begin
        if (valid0) begin
            vcnt0++;
            check("valid0_one_cycle", 32'(vprev0), 32'h0);
            total++;
            assert (exp0.size() > 0) else begin
                bad++;
                $error("FAIL valid0_unexpected: observed=%0h expected=none", data0);
            end
            if (exp0.size() > 0) begin
                e0 = exp0.pop_front();
                check("data0", 32'(data0), 32'(e0[7:0]));
                check("perr0", 32'(perr0), 32'(e0[8]));
            end
        end
        if (perr0) check("perr0_with_valid", 32'(valid0), 32'h1);
        if (ferr0) begin
            fcnt0++;
            check("ferr0_no_valid", 32'(valid0), 32'h0);
        end
        vprev0 <= valid0;
    end

    // Scoreboard side for the even-parity instance.
    always @(negedge clk) begin
        if (valid1) begin
            vcnt1++;
            check("valid1_one_cycle", 32'(vprev1), 32'h0);
            total++;
            assert (exp1.size() > 0) else begin
                bad++;
                $error("FAIL valid1_unexpected: observed=%0h expected=none", data1);
            end
            if (exp1.size() > 0) begin
                e1 = exp1.pop_front();
                check("data1", 32'(data1), 32'(e1[7:0]));
                check("perr1", 32'(perr1), 32'(e1[8]));
            end
        end
        if (perr1) check("perr1_with_valid", 32'(valid1), 32'h1);
        if (ferr1) fcnt1++;
        vprev1 <= valid1;
    end

    task automatic drive(input int which, input logic v, input int clks);
        if (which == 0) rxd = v;
        else rxd_p = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send_tail(input int which, input logic [7:0] d, input bit par_en,
                             input logic par_bit, input logic stop_v);
        for (int i = 0; i < 8; i++) drive(which, d[i], Cpb);
        if (par_en) drive(which, par_bit, Cpb);
        drive(which, stop_v, Cpb);
    endtask

    task automatic send(input int which, input logic [7:0] d, input bit par_en,
                        input logic par_bit, input logic stop_v);
        drive(which, 1'b0, Cpb);
        send_tail(which, d, par_en, par_bit, stop_v);
    endtask

    task automatic wait_count(input string tag, input int which, input int target);
        int n = 0;
        while (((which == 0) ? vcnt0 : vcnt1) < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, (which == 0) ? vcnt0 : vcnt1, target);
    endtask

    initial begin
        int         f0;
        bit         saw_busy, led_low;
        logic [7:0] d;

        rst_n = 1'b0;
        rxd   = 1'b1;
        rxd_p = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data0), 32'h0);
        check("rst_valid", 32'(valid0), 32'h0);
        check("rst_flags", 32'({perr0, ferr0}), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_led", 32'(led0), 32'h1);
        check("rst_p_busy_led", 32'({busy1, led1}), 32'h1);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 frame 0xA5
        exp0.push_back({1'b0, 8'hA5});
        drive(0, 1'b0, Cpb);
        check("a5_busy", 32'(busy0), 32'h1);
        check("a5_led_on", 32'(led0), 32'h0);
        send_tail(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_count("a5_valid_count", 0, 1);
        drive(0, 1'b1, 20);
        check("a5_data_hold", 32'(data0), 32'hA5);
        check("a5_led_expired", 32'(led0), 32'h1);
        check("a5_no_ferr", fcnt0, 0);

        // Even parity: 0x03 with parity bit 1 is a mismatch, 0x07 with 1 is good.
        d = 8'h03;
        exp1.push_back({(^d) ^ 1'b1, d});
        send(1, d, 1'b1, 1'b1, 1'b1);
        wait_count("p03_valid_count", 1, 1);
        d = 8'h07;
        exp1.push_back({(^d) ^ 1'b1, d});
        send(1, d, 1'b1, 1'b1, 1'b1);
        wait_count("p07_valid_count", 1, 2);
        drive(1, 1'b1, 10);
        check("p07_data", 32'(data1), 32'h07);
        check("p_no_ferr", fcnt1, 0);

        // Stop bit low, line held low for 200 clocks.
        f0 = fcnt0;
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 200);
        check("brk_busy_held", 32'(busy0), 32'h1);
        check("brk_data_hold", 32'(data0), 32'hA5);
        check("brk_one_ferr", fcnt0, f0 + 1);
        drive(0, 1'b1, 10);
        check("brk_idle_after_high", 32'(busy0), 32'h0);
        check("brk_still_one_ferr", fcnt0, f0 + 1);
        check("brk_no_valid", vcnt0, 1);

        // Four-clock low glitch.
        check("glitch_led_idle", 32'(led0), 32'h1);
        drive(0, 1'b0, 4);
        rxd      = 1'b1;
        saw_busy = 1'b0;
        led_low  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (busy0) saw_busy = 1'b1;
            if (!led0) led_low = 1'b1;
        end
        check("glitch_busy_seen", 32'(saw_busy), 32'h1);
        check("glitch_led_stays", 32'(led_low), 32'h0);
        check("glitch_back_idle", 32'(busy0), 32'h0);
        check("glitch_no_pulses", vcnt0 + fcnt0, 1 + f0 + 1);

        // Back-to-back frames with zero idle gap.
        exp0.push_back({1'b0, 8'h00});
        exp0.push_back({1'b0, 8'hFF});
        send(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 10);
        wait_count("b2b_valid_count", 0, 3);
        check("b2b_last_data", 32'(data0), 32'hFF);

        // Reset in the middle of the data bits, then a clean frame.
        drive(0, 1'b0, Cpb);
        drive(0, 1'b1, Cpb);
        drive(0, 1'b0, Cpb);
        drive(0, 1'b1, Cpb / 2);
        rst_n = 1'b0;
        rxd   = 1'b1;
        #1;
        check("midrst_busy", 32'(busy0), 32'h0);
        check("midrst_data", 32'(data0), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_valid", vcnt0, 3);
        exp0.push_back({1'b0, 8'h5A});
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 10);
        wait_count("after_rst_valid_count", 0, 4);
        check("after_rst_data", 32'(data0), 32'h5A);

        check("sb0_drained", exp0.size(), 0);
        check("sb1_drained", exp1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
